// File: rtl/sha3_scan_result_serializer_pkg.sv
// Shared types and helpers for the scan-result serializer: result record,
// packet length and the word-select function used by the output mux.
package sha3_scan_pkg;

  localparam int WORDS_PER_RESULT = 9;
  localparam int IDX_W            = 4;

  typedef struct packed {
    logic [31:0]  nonce;
    logic [255:0] hash;
  } scan_result_t;

  typedef enum logic {S_IDLE, S_SEND} ser_state_t;

  // Word 0 is the nonce; words 1..8 walk the digest from bit 0 upward.
  function automatic logic [31:0] result_word(scan_result_t r, logic [IDX_W-1:0] idx);
    logic [7:0][31:0] lanes;
    lanes = r.hash;
    if (idx == '0) return r.nonce;
    return lanes[3'(idx - 1'b1)];
  endfunction

endpackage

// File: rtl/sha3_scan_result_serializer_if.sv
// Scanner result bus plus host word stream, bundled for the serializer.
interface sha3_scan_result_serializer_if;
  logic         in_valid;
  logic [31:0]  in_nonce;
  logic [255:0] in_hash;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;

  modport slave  (input  in_valid, in_nonce, in_hash, out_ready,
                  output out_valid, out_data, out_last);
  modport master (output in_valid, in_nonce, in_hash, out_ready,
                  input  out_valid, out_data, out_last);
endinterface

// File: rtl/sha3_scan_result_serializer_ring.sv
// Circular result buffer: one write port, one async read of the head entry.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module sha3_result_ring
  import sha3_scan_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  scan_result_t             wr_data,
  input  logic                     rd_en,
  output scan_result_t             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  scan_result_t mem [DEPTH];
  logic [AW:0]  wp, rp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
    end
  end

  // When full with a same-cycle pop, wp aliases the head slot; the head is
  // consumed on this edge, so overwriting it is safe.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rp[AW-1:0]];
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign level   = wp - rp;

endmodule

// File: rtl/sha3_scan_result_serializer.sv
// Captures scanner results without back-pressure and streams each as nine
// 32-bit words; overflowing results are dropped and counted.
module sha3_scan_result_serializer
  import sha3_scan_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  sha3_scan_result_serializer_if.slave bus,
  input  logic                       clr_overflow,
  output logic [$clog2(DEPTH):0]     level,
  output logic [DROP_W-1:0]          dropped,
  output logic                       overflow
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_RESULT - 1);

  ser_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_result_t     head, wr_data;
  logic             full, empty, valid, hs, pop, push, drop;

  assign wr_data = '{nonce: bus.in_nonce, hash: bus.in_hash};
  assign hs      = valid & bus.out_ready;
  assign pop     = hs & (idx_q == IDX_LAST);
  // A full buffer still accepts when the head's last word leaves this cycle.
  assign push    = bus.in_valid & (~full | pop);
  assign drop    = bus.in_valid & full & ~pop;

  sha3_result_ring #(.DEPTH(DEPTH)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (push || !empty) state_d = S_SEND;
      end
      S_SEND: begin
        valid = 1'b1;
        if (hs) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (level == LW'(1) && !push) state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? result_word(head, idx_q) : 32'h0;
  assign bus.out_last  = valid && (idx_q == IDX_LAST);

  // A drop outranks a same-cycle clear, so the counter restarts at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropped  <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_overflow)        dropped <= DROP_W'(1);
      else if (dropped != '1)  dropped <= dropped + DROP_W'(1);
    end else if (clr_overflow) begin
      dropped  <= '0;
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha3_scan_result_serializer.sv
// Randomized bench for the scan-result serializer against a word-queue model.
module tb_sha3_scan_result_serializer;
  localparam int DEPTH  = 4;
  localparam int DROP_W = 4;
  localparam int DMAX   = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic [2:0]        level;
  logic [DROP_W-1:0] dropped;
  logic              overflow;
  int                passed = 0;
  int                total  = 0;

  // Model: every pending output word as {last, data}, plus held-result count.
  logic [32:0] wq[$];
  int          ent   = 0;
  int          mdrop = 0;
  bit          movf  = 1'b0;

  sha3_scan_result_serializer_if tif();

  sha3_scan_result_serializer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (tif.slave),
    .clr_overflow (clr),
    .level        (level),
    .dropped      (dropped),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  function automatic logic [41:0] got_vec();
    return {tif.out_valid, tif.out_last, tif.out_data, level, dropped, overflow};
  endfunction

  function automatic logic [41:0] exp_vec();
    logic [32:0] f;
    f = (wq.size() > 0) ? wq[0] : 33'h0;
    return {wq.size() > 0, f[32], f[31:0], 3'(ent), 4'(mdrop), movf};
  endfunction

  task automatic model_reset();
    wq.delete();
    ent = 0; mdrop = 0; movf = 1'b0;
  endtask

  // Drive one clock of stimulus, advance the model across the edge, and
  // return at the following falling edge where outputs are sampled.
  task automatic cycle(input bit v, input bit rdy, input bit c,
                       input logic [31:0] n, input logic [255:0] h);
    bit hs, last, acc;
    tif.in_valid  = v;
    tif.in_nonce  = n;
    tif.in_hash   = h;
    tif.out_ready = rdy;
    clr           = c;
    hs   = (wq.size() > 0) && rdy;
    last = hs && wq[0][32];
    acc  = v && (ent < DEPTH || last);
    @(posedge clk);
    if (hs)   void'(wq.pop_front());
    if (last) ent--;
    if (acc) begin
      wq.push_back({1'b0, n});
      for (int k = 0; k < 8; k++) wq.push_back({k == 7, h[32*k +: 32]});
      ent++;
    end
    if (v && !acc) begin
      movf  = 1'b1;
      mdrop = c ? 1 : (mdrop == DMAX ? DMAX : mdrop + 1);
    end else if (c) begin
      mdrop = 0; movf = 1'b0;
    end
    @(negedge clk);
    tif.in_valid = 1'b0;
    clr          = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (got_vec() !== 42'h0) $display("FAIL reset_hold: got %h exp %h", got_vec(), 42'h0);
    else passed++;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    total++;
    if (got_vec() !== exp_vec()) $display("FAIL reset_release: got %h exp %h", got_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_single();
    logic [31:0] w[9];
    w = '{32'h0000_00A5, 32'h3333_4444, 32'h1111_2222, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    cycle(1, 1, 0, 32'h0000_00A5, 256'h1111_2222_3333_4444);
    for (int k = 0; k < 9; k++) begin
      total++;
      if ({tif.out_valid, tif.out_last, tif.out_data} !== {1'b1, k == 8, w[k]})
        $display("FAIL single_word%0d: got %b %b %h exp 1 %b %h", k,
                 tif.out_valid, tif.out_last, tif.out_data, k == 8, w[k]);
      else passed++;
      total++;
      if (got_vec() !== exp_vec()) $display("FAIL single_model%0d: got %h exp %h", k, got_vec(), exp_vec());
      else passed++;
      cycle(0, 1, 0, '0, '0);
    end
    total++;
    if ({tif.out_valid, level} !== 4'b0000) $display("FAIL single_drained: got %b %0d exp 0 0", tif.out_valid, level);
    else passed++;
  endtask

  task automatic test_stall();
    logic [31:0]  n;
    logic [255:0] h;
    n = $urandom; h = rand_hash();
    cycle(1, 0, 0, n, h);
    repeat (3) cycle(0, 1, 0, '0, '0);
    for (int s = 0; s < 2; s++) begin
      cycle(0, 0, 0, '0, '0);
      total++;
      if (tif.out_data !== h[95:64]) $display("FAIL stall_hold%0d: got %h exp %h", s, tif.out_data, h[95:64]);
      else passed++;
    end
    cycle(0, 1, 0, '0, '0);
    total++;
    if (tif.out_data !== h[127:96]) $display("FAIL stall_advance: got %h exp %h", tif.out_data, h[127:96]);
    else passed++;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (got_vec() !== exp_vec()) $display("FAIL stall_model%0d: got %h exp %h", k, got_vec(), exp_vec());
      else passed++;
      cycle(0, 1, 0, '0, '0);
    end
  endtask

  task automatic test_overflow();
    cycle(0, 0, 1, '0, '0);
    for (int i = 1; i <= 5; i++) cycle(1, 0, 0, 32'(i), rand_hash());
    total++;
    if ({level, dropped, overflow} !== {3'd4, 4'd1, 1'b1})
      $display("FAIL overflow_state: got %0d %0d %b exp 4 1 1", level, dropped, overflow);
    else passed++;
    for (int c = 0; c < 36; c++) begin
      if (c % 9 == 0) begin
        total++;
        if (tif.out_data !== 32'(c / 9 + 1)) $display("FAIL overflow_order%0d: got %h exp %h", c / 9, tif.out_data, 32'(c / 9 + 1));
        else passed++;
      end
      total++;
      if (got_vec() !== exp_vec()) $display("FAIL overflow_model%0d: got %h exp %h", c, got_vec(), exp_vec());
      else passed++;
      cycle(0, 1, 0, '0, '0);
    end
  endtask

  task automatic test_full_pop_push();
    cycle(0, 0, 1, '0, '0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 32'h10 + 32'(i), rand_hash());
    repeat (8) cycle(0, 1, 0, '0, '0);
    total++;
    if ({tif.out_last, level} !== {1'b1, 3'd4}) $display("FAIL fpp_setup: got %b %0d exp 1 4", tif.out_last, level);
    else passed++;
    cycle(1, 1, 0, 32'h14, rand_hash());
    total++;
    if ({level, dropped, tif.out_data} !== {3'd4, 4'd0, 32'h11})
      $display("FAIL fpp_accept: got %0d %0d %h exp 4 0 11", level, dropped, tif.out_data);
    else passed++;
    for (int c = 0; c < 36; c++) begin
      total++;
      if (got_vec() !== exp_vec()) $display("FAIL fpp_model%0d: got %h exp %h", c, got_vec(), exp_vec());
      else passed++;
      cycle(0, 1, 0, '0, '0);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, $urandom, rand_hash());
    total++;
    if ({dropped, overflow} !== {4'hF, 1'b1}) $display("FAIL sat_hold: got %0d %b exp 15 1", dropped, overflow);
    else passed++;
    cycle(1, 0, 1, $urandom, rand_hash());
    total++;
    if ({dropped, overflow} !== {4'd1, 1'b1}) $display("FAIL sat_drop_clr: got %0d %b exp 1 1", dropped, overflow);
    else passed++;
    cycle(0, 0, 1, '0, '0);
    total++;
    if ({dropped, overflow} !== {4'd0, 1'b0}) $display("FAIL sat_clr: got %0d %b exp 0 0", dropped, overflow);
    else passed++;
    repeat (36) cycle(0, 1, 0, '0, '0);
    total++;
    if (got_vec() !== exp_vec()) $display("FAIL sat_drain: got %h exp %h", got_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [31:0] n;
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, $urandom, rand_hash());
    repeat (5) cycle(0, 1, 0, '0, '0);
    total++;
    if (got_vec() !== exp_vec()) $display("FAIL midrst_setup: got %h exp %h", got_vec(), exp_vec());
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({tif.out_valid, level} !== 4'b0000) $display("FAIL midrst_async: got %b %0d exp 0 0", tif.out_valid, level);
    else passed++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    n = $urandom;
    cycle(1, 0, 0, n, rand_hash());
    total++;
    if ({tif.out_valid, tif.out_data, level} !== {1'b1, n, 3'd1})
      $display("FAIL midrst_repush: got %b %h %0d exp 1 %h 1", tif.out_valid, tif.out_data, level, n);
    else passed++;
    repeat (9) cycle(0, 1, 0, '0, '0);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      bit v;
      v = (c < 300) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      cycle(v, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom, rand_hash());
      total++;
      if (got_vec() !== exp_vec()) begin
        if (errs < 10) $display("FAIL random%0d: got %h exp %h", c, got_vec(), exp_vec());
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    tif.in_valid  = 1'b0;
    tif.in_nonce  = '0;
    tif.in_hash   = '0;
    tif.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_full_pop_push();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sha3_scan_result_serializer.md
# sha3_scan_result_serializer

Downstream of the packed-by-6 scanner: captures each scan result (nonce + 256-bit digest) the moment the scanner emits it, buffers up to DEPTH results, and streams them to the host link as 32-bit words with valid/ready handshake. The scanner cannot be stalled, so the block never back-pressures it. Overflow drops the new result and is counted.

## Interface
- DEPTH, 4: result entries buffered; power of two, 2..16.
- DROP_W, 16: width of the saturating dropped-result counter.
- clk  in  1  sole clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  one-cycle strobe from scanner result bus; one result per asserted cycle.
- in_nonce  in  32  nonce producing the result.
- in_hash  in  256  digest lanes 0..3, lane 0 in bits [63:0].
- out_valid  out  1  word available.
- out_ready  in  1  host accepts word when high with out_valid.
- out_data  out  32  current word.
- out_last  out  1  high on final word (index 8) of a result.
- level  out  $clog2(DEPTH)+1  entries held, including the one being sent.
- dropped  out  DROP_W  results lost to overflow, saturates at all-ones.
- overflow  out  1  sticky, set on any drop.
- clr_overflow  in  1  clears overflow and dropped. Lower priority than a same-cycle drop, so the counter reads 1 after a simultaneous drop.

## Operation
- Packet per result: 9 words. Word 0 is in_nonce. Word k (1..8) is in_hash[32k-1 -: 32], low half first.
- Storage: circular buffer, write pointer wp, read pointer rp, both $clog2(DEPTH)+1 bits. Empty when pointers are equal. Full when MSBs differ and the rest are equal. Pointers wrap naturally.
- Push: in_valid and not full → entry written at wp, wp+1. Push when full → no write, dropped+1 (saturating), overflow set.
- Full push with same-cycle pop of the head's last word (out_valid & out_ready & out_last) → accepted. The freed slot is reused and level is unchanged.
- Serializer FSM:
  - IDLE: empty. out_valid=0, idx=0.
  - SEND: not empty. out_valid=1. out_data/out_last are muxed from entry rp at word idx.
  - Handshake with idx<8 → idx+1.
  - Handshake with idx=8 → idx=0, rp+1. Go to SEND if another entry remains, else IDLE.
- Stream rule: once out_valid rises, out_data and out_last hold until the handshake. Pushes never alter the head entry.
- level = wp - rp (modular).

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, level=0, dropped=0, overflow=0, wp=rp=0, idx=0, state IDLE. Reset mid-packet discards all entries immediately.
- Push at edge N → level and out_valid reflect it after edge N (visible cycle N+1). Input-to-first-word latency is 1 cycle.
- With out_ready held high, a result drains in 9 cycles. Back-to-back entries stream with no gap cycle: word 0 of the next result follows word 8 of the previous.
- Push into empty and clr_overflow have no interaction with the serializer.
- Sustained scanner rate above 1 result / 9 cycles overflows after DEPTH results.

## Structure
- sha3_scan_pkg holds:
  - typedef scan_result_t struct {logic [31:0] nonce; logic [255:0] hash;}
  - localparam WORDS_PER_RESULT = 9
  - function result_word(scan_result_t, idx)
- Sub-module sha3_result_ring: storage array plus wp/rp/full/empty/level logic, one write port and one async-read port. The top module holds the FSM, word mux, and drop accounting.

## Test plan
- Single push nonce=0x0000_00A5, hash lane0=0x1111_2222_3333_4444, other lanes 0, out_ready=1 → words 0x000000A5, 0x33334444, 0x11112222, then six zeros. out_last only on the 9th word. level returns 0.
- out_ready toggling 1,0,0,1 during word 3 → word 3 is held stable across the stall and then advances. No word is skipped or repeated.
- Push 5 results with DEPTH=4 while out_ready=0 → level=4, dropped=1, overflow=1. Releasing ready drains nonces 1..4 in order.
- Full buffer; push on the same cycle as out_last handshake → accepted, level stays 4, dropped unchanged.
- dropped at all-ones plus another drop → stays all-ones. Drop with clr_overflow in the same cycle → dropped=1, overflow=1.
- Assert rst while idx=5 with 3 entries held → out_valid=0 and level=0 immediately. A new push afterwards emits from word 0.
